// File: rtl/bus_arbiter_mux_pkg.sv
// rtl/bus_arbiter_mux_pkg.sv - shared types and processor defaults for the bus arbiter/mux
package bus_pkg;

  typedef enum logic {MODE_DIRECT = 1'b0, MODE_RR = 1'b1} bus_mode_t;

  localparam int BUS_WIDTH = 16;
  localparam int BUS_NSRC  = 8;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// rtl/bus_arbiter_mux_if.sv - source/select inputs and registered output handshake of the bus arbiter/mux
interface bus_arbiter_mux_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N_SRC = BUS_NSRC
);
  localparam int SEL_W = $clog2(N_SRC);

  bus_mode_t              mode;
  logic [SEL_W-1:0]       sel;
  logic [N_SRC-1:0]       req;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic [N_SRC-1:0]       gnt;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_src;
  logic                   sel_err;

  modport slave (
    input  mode, sel, req, data_in, out_ready,
    output gnt, out_valid, out_data, out_src, sel_err
  );

  modport master (
    output mode, sel, req, data_in, out_ready,
    input  gnt, out_valid, out_data, out_src, sel_err
  );

endinterface

// File: rtl/bus_arbiter_mux_rr_pick.sv
// rtl/bus_arbiter_mux_rr_pick.sv - rotating priority encoder: first request after ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int PW = $clog2(N);

  // Walk from the farthest offset back to ptr+1 so the nearest hit is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - direct-select or round-robin N-to-1 bus mux with a 1-deep registered output
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N_SRC = BUS_NSRC
) (
  input  logic              clk,
  input  logic              rst,
  bus_arbiter_mux_if.slave  bus
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             load_ok;
  logic             sel_ok;
  logic             grant;
  logic [SEL_W-1:0] grant_idx;
  logic [N_SRC-1:0] gnt;
  logic [WIDTH-1:0] src_word [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_word[i] = bus.data_in[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N(N_SRC)) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign load_ok = !out_valid_q || bus.out_ready;
  assign sel_ok  = int'(bus.sel) < N_SRC;

  always_comb begin
    grant       = 1'b0;
    grant_idx   = '0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    sel_err_d   = 1'b0;

    if (bus.mode == MODE_DIRECT) begin
      if (load_ok && sel_ok && bus.req[bus.sel]) begin
        grant     = 1'b1;
        grant_idx = bus.sel;
      end
      sel_err_d = load_ok && !sel_ok;
    end else if (load_ok && rr_found) begin
      grant     = 1'b1;
      grant_idx = rr_idx;
      rr_ptr_d  = rr_idx;
    end

    // A grant in the reset cycle would be lost anyway; suppress it at the source.
    if (rst) grant = 1'b0;

    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = src_word[grant_idx];
      out_src_d   = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < N_SRC; i++) begin
      gnt[i] = grant && (grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= SEL_W'(N_SRC - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - self-checking bench for bus_arbiter_mux (8-source main DUT, 6-source DUT for sel range)
module tb_bus_arbiter_mux;
  import bus_pkg::*;

  localparam int NS = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter_mux_if #(.WIDTH(16), .N_SRC(8)) bus ();
  bus_arbiter_mux_if #(.WIDTH(16), .N_SRC(6)) bus6 ();

  bus_arbiter_mux #(.WIDTH(16), .N_SRC(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  bus_arbiter_mux #(.WIDTH(16), .N_SRC(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

  // Reference model of the 8-source DUT: pointer, held word and error flag.
  logic        m_valid;
  logic [15:0] m_data;
  int          m_src;
  int          m_ptr;
  logic        m_err;

  // Winner is the requester at the smallest positive circular distance from the pointer.
  function automatic int exp_idx();
    int best, bestd, d;
    if (rst) return -1;
    if (m_valid && !bus.out_ready) return -1;
    if (bus.mode == MODE_DIRECT) return (int'(bus.sel) < NS && bus.req[bus.sel]) ? int'(bus.sel) : -1;
    best = -1; bestd = NS + 1;
    for (int i = 0; i < NS; i++) begin
      d = (i - m_ptr - 1 + 2*NS) % NS;
      if (bus.req[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  function automatic logic [7:0] exp_gnt();
    int g;
    g = exp_idx();
    return (g < 0) ? 8'h00 : (8'h01 << g);
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_idx();
    if (rst) begin
      m_valid = 1'b0; m_data = 16'h0; m_src = 0; m_ptr = NS - 1; m_err = 1'b0;
    end else begin
      m_err = (bus.mode == MODE_DIRECT) && (!m_valid || bus.out_ready) && (int'(bus.sel) >= NS);
      if (g >= 0) begin
        m_valid = 1'b1; m_data = bus.data_in[g*16 +: 16]; m_src = g;
        if (bus.mode == MODE_RR) m_ptr = g;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next(); next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mode = MODE_RR; bus.req = 8'hFF; bus.out_ready = 1'b1;
    bus6.req = 6'h3F;
    next(); next();
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got=%h exp=00", bus.gnt); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", bus.out_data); end
    n_checks++; if (bus.out_src !== 3'd0) begin n_fail++; $display("FAIL reset_src got=%0d exp=0", bus.out_src); end
    n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_selerr got=%b exp=0", bus.sel_err); end
    n_checks++; if (bus6.gnt !== 6'h00) begin n_fail++; $display("FAIL reset_gnt6 got=%h exp=00", bus6.gnt); end
    bus6.req = 6'h00;
    next();
    rst = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    bus.mode = MODE_DIRECT; bus.sel = 3'd3; bus.req = 8'h08; bus.out_ready = 1'b1;
    bus.data_in[3*16 +: 16] = 16'hA5A5;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL direct_gnt got=%h exp=08", bus.gnt); end
    next();
    bus.req = 8'h00;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL direct_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'hA5A5) begin n_fail++; $display("FAIL direct_data got=%h exp=a5a5", bus.out_data); end
    n_checks++; if (bus.out_src !== 3'd3) begin n_fail++; $display("FAIL direct_src got=%0d exp=3", bus.out_src); end
    next();
  endtask

  task automatic test_rr_order();
    logic [7:0] e;
    do_reset();
    bus.mode = MODE_RR; bus.req = 8'hFF; bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      e = 8'h01 << (k % 8);
      n_checks++; if (bus.gnt !== e) begin n_fail++; $display("FAIL rr_order_gnt k=%0d got=%h exp=%h", k, bus.gnt, e); end
      if (k > 0) begin
        n_checks++; if (bus.out_src !== 3'((k - 1) % 8)) begin n_fail++; $display("FAIL rr_order_src k=%0d got=%0d exp=%0d", k, bus.out_src, (k - 1) % 8); end
      end
      next();
    end
    bus.req = 8'h00;
  endtask

  task automatic test_wrap();
    int wexp [3] = '{7, 1, 7};
    do_reset();
    bus.mode = MODE_RR; bus.req = 8'h02; bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h02) begin n_fail++; $display("FAIL wrap_setup got=%h exp=02", bus.gnt); end
    next();
    bus.req = 8'h82;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.gnt !== (8'h01 << wexp[k])) begin n_fail++; $display("FAIL wrap_gnt k=%0d got=%h exp=%h", k, bus.gnt, 8'h01 << wexp[k]); end
      next();
    end
    bus.req = 8'h00;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mode = MODE_RR; bus.req = 8'h01; bus.out_ready = 1'b1;
    bus.data_in[0 +: 16] = 16'h1111;
    next();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req = 8'($urandom_range(1, 255));
      bus.data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_checks++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL bp_gnt k=%0d got=%h exp=00", k, bus.gnt); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, bus.out_valid); end
      n_checks++; if (bus.out_data !== 16'h1111) begin n_fail++; $display("FAIL bp_data k=%0d got=%h exp=1111", k, bus.out_data); end
      n_checks++; if (bus.out_src !== 3'd0) begin n_fail++; $display("FAIL bp_src k=%0d got=%0d exp=0", k, bus.out_src); end
      next();
    end
    bus.out_ready = 1'b1; bus.req = 8'h04; bus.data_in[2*16 +: 16] = 16'h2222;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h04) begin n_fail++; $display("FAIL bp_release_gnt got=%h exp=04", bus.gnt); end
    next();
    bus.req = 8'h00;
    @(negedge clk);
    n_checks++; if (bus.out_data !== 16'h2222 || bus.out_src !== 3'd2 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_word got=%h/%0d/%b exp=2222/2/1", bus.out_data, bus.out_src, bus.out_valid);
    end
    next();
  endtask

  task automatic test_sel_err();
    bus6.mode = MODE_DIRECT; bus6.sel = 3'd0; bus6.req = 6'h3F; bus6.out_ready = 1'b1;
    bus6.data_in[0 +: 16] = 16'h0606;
    @(negedge clk);
    n_checks++; if (bus6.gnt !== 6'h01) begin n_fail++; $display("FAIL selerr_load_gnt got=%h exp=01", bus6.gnt); end
    next();
    bus6.sel = 3'd7;
    @(negedge clk);
    n_checks++; if (bus6.gnt !== 6'h00) begin n_fail++; $display("FAIL selerr_gnt got=%h exp=00", bus6.gnt); end
    n_checks++; if (bus6.out_valid !== 1'b1) begin n_fail++; $display("FAIL selerr_prevalid got=%b exp=1", bus6.out_valid); end
    next();
    bus6.sel = 3'd0; bus6.req = 6'h00;
    @(negedge clk);
    n_checks++; if (bus6.sel_err !== 1'b1) begin n_fail++; $display("FAIL selerr_pulse got=%b exp=1", bus6.sel_err); end
    n_checks++; if (bus6.out_valid !== 1'b0) begin n_fail++; $display("FAIL selerr_valid got=%b exp=0", bus6.out_valid); end
    next();
    @(negedge clk);
    n_checks++; if (bus6.sel_err !== 1'b0) begin n_fail++; $display("FAIL selerr_width got=%b exp=0", bus6.sel_err); end
    next();
  endtask

  task automatic test_reset_mid();
    bus.mode = MODE_RR; bus.req = 8'h01; bus.out_ready = 1'b1;
    bus.data_in[0 +: 16] = 16'h7777;
    next();
    bus.req = 8'h00; bus.out_ready = 1'b0;
    next();
    rst = 1'b1; bus.req = 8'hFF;
    @(negedge clk);
    n_checks++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL rstmid_gnt got=%h exp=00", bus.gnt); end
    next();
    rst = 1'b0; bus.req = 8'h30; bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_cleared got=%b/%h exp=0/0000", bus.out_valid, bus.out_data);
    end
    n_checks++; if (bus.gnt !== 8'h10) begin n_fail++; $display("FAIL rstmid_first_gnt got=%h exp=10", bus.gnt); end
    next();
    bus.req = 8'h00;
    @(negedge clk);
    n_checks++; if (bus.out_src !== 3'd4) begin n_fail++; $display("FAIL rstmid_src got=%0d exp=4", bus.out_src); end
    next();
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.mode = ($urandom_range(0, 2) == 0) ? MODE_DIRECT : MODE_RR;
      bus.sel = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.req = 8'h00;
        1:       bus.req = 8'h01 << $urandom_range(0, 7);
        default: bus.req = 8'($urandom);
      endcase
      bus.data_in = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e = exp_gnt();
      n_checks++; if (bus.gnt !== e) begin n_fail++; $display("FAIL rand_gnt c=%0d got=%h exp=%h", c, bus.gnt, e); end
      n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.out_valid, m_valid); end
      n_checks++; if (bus.out_data !== m_data) begin n_fail++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, bus.out_data, m_data); end
      n_checks++; if (bus.out_src !== 3'(m_src)) begin n_fail++; $display("FAIL rand_src c=%0d got=%0d exp=%0d", c, bus.out_src, m_src); end
      n_checks++; if (bus.sel_err !== m_err) begin n_fail++; $display("FAIL rand_selerr c=%0d got=%b exp=%b", c, bus.sel_err, m_err); end
      next();
    end
    rst = 1'b0; bus.req = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = MODE_DIRECT; bus.sel = '0; bus.req = '0; bus.data_in = '0; bus.out_ready = 1'b1;
    bus6.mode = MODE_DIRECT; bus6.sel = '0; bus6.req = '0; bus6.data_in = '0; bus6.out_ready = 1'b1;
    test_reset();
    test_direct();
    test_rr_order();
    test_wrap();
    test_backpressure();
    test_sel_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
